// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, FSM states and the command record.
package alu_pkg;

    localparam int W_DATA_IN  = 8;
    localparam int W_DATA_OP  = 2;
    localparam int W_DATA_OUT = 8;
    localparam int DEPTH      = 4;

    localparam logic [W_DATA_OP-1:0] ALU_ADD = 2'd0;
    localparam logic [W_DATA_OP-1:0] ALU_SUB = 2'd1;
    localparam logic [W_DATA_OP-1:0] ALU_MUL = 2'd2;
    localparam logic [W_DATA_OP-1:0] ALU_DIV = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic [W_DATA_IN-1:0] a;
        logic [W_DATA_IN-1:0] b;
        logic [W_DATA_OP-1:0] op;
    } alu_cmd_t;

    function automatic logic is_div_zero(input alu_cmd_t cmd);
        return (cmd.op == ALU_DIV) && (cmd.b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t commands.
// Latency: push visible at the head one cycle later (no bypass).
// Backpressure: o_full blocks pushes; pops on empty are ignored.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_push,
    input  alu_cmd_t i_dat,
    input  logic     i_pop,
    output alu_cmd_t o_dat,
    output logic     o_full,
    output logic     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    alu_cmd_t    mem_q [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_dat   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_push && !o_full) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (i_pop && !o_empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_dat;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the registered 8-bit ALU; optional ALU_ISSUE_STATS_EN adds response counters.
// Latency: push at E0 into an idle block gives o_rsp_valid after E3; 1 result per 3 cycles.
// Backpressure: o_rsp_* held until i_rsp_ready; o_cmd_ready drops when the FIFO is full.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = alu_pkg::DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [W_DATA_IN-1:0]  i_cmd_a,
    input  logic [W_DATA_IN-1:0]  i_cmd_b,
    input  logic [W_DATA_OP-1:0]  i_cmd_op,
    output logic [W_DATA_IN-1:0]  o_alu_a,
    output logic [W_DATA_IN-1:0]  o_alu_b,
    output logic [W_DATA_OP-1:0]  o_alu_op,
    input  logic [W_DATA_OUT-1:0] i_alu_result,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [W_DATA_OUT-1:0] o_rsp_result,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0]           o_cmd_cnt,
    output logic [15:0]           o_err_cnt,
`endif
    output logic                  o_rsp_err
);

    state_e                state_q, state_d;
    logic                  cmd_en_q;
    logic                  fifo_full, fifo_empty, pop;
    alu_cmd_t              cmd_in, head;
    logic [W_DATA_IN-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [W_DATA_OP-1:0]  alu_op_q, alu_op_d;
    logic                  dz_q, dz_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [W_DATA_OUT-1:0] rsp_result_q, rsp_result_d;

    assign cmd_in      = '{a: i_cmd_a, b: i_cmd_b, op: i_cmd_op};
    assign o_cmd_ready = cmd_en_q && !fifo_full;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_cmd_valid && o_cmd_ready),
        .i_dat   (cmd_in),
        .i_pop   (pop),
        .o_dat   (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        dz_d         = dz_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                rsp_valid_d  = 1'b1;
                rsp_err_d    = dz_q;
                rsp_result_d = dz_q ? '1 : i_alu_result;
                state_d      = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A zero divisor is replaced by 1 so the ALU never sees x/0.
        if (pop) begin
            dz_d     = is_div_zero(head);
            alu_a_d  = head.a;
            alu_b_d  = is_div_zero(head) ? W_DATA_IN'(1) : head.b;
            alu_op_d = head.op;
        end
    end

    always_ff @(posedge i_clk) begin
        cmd_en_q <= !i_rst;
        if (i_rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            dz_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            dz_q         <= dz_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign o_alu_a      = alu_a_q;
    assign o_alu_b      = alu_b_q;
    assign o_alu_op     = alu_op_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_err    = rsp_err_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] cmd_cnt_q, err_cnt_q;
    logic        rsp_hs;

    assign rsp_hs = rsp_valid_q && i_rsp_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (rsp_hs) begin
            if (cmd_cnt_q != 16'hFFFF) cmd_cnt_q <= cmd_cnt_q + 16'd1;
            if (rsp_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign o_cmd_cnt = cmd_cnt_q;
    assign o_err_cnt = err_cnt_q;
`else
    // Without statistics the response handshake has no further observers.
`endif

endmodule
